// File: rtl/noc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_seq_pkg
// Brief    : Shared state encoding, widths and default parameter values for
//            the NoC injection sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package noc_seq_pkg;

    localparam int ITER_W = 16;

    localparam int c_DEF_NUM_CH      = 4;
    localparam int c_DEF_NUM_ITER    = 5;
    localparam int c_DEF_GAP_CYC     = 2;
    localparam int c_DEF_TIMEOUT_CYC = 1024;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PH1    = 3'd1,
        ST_PH2    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_GAP    = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/noc_seq_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : noc_seq_watchdog
// Brief    : WAIT-phase cycle counter; expired flags the last allowed cycle.
// Revision : 1.0 - initial release
// ============================================================================
module noc_seq_watchdog
    import noc_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = c_DEF_TIMEOUT_CYC
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int c_CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            r_count <= '0;
        end else if (enable && (r_count != c_LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = enable && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/noc_inject_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : noc_inject_sequencer
// Brief    : Drives two-phase start pulses to NUM_CH channels, collects DONE,
//            repeats NUM_ITER times and reports sticky PASS/FAIL.
// Revision : 1.0 - initial release
// ============================================================================
module noc_inject_sequencer
    import noc_seq_pkg::*;
#(
    parameter int NUM_CH      = c_DEF_NUM_CH,
    parameter int NUM_ITER    = c_DEF_NUM_ITER,
    parameter int GAP_CYC     = c_DEF_GAP_CYC,
    parameter int TIMEOUT_CYC = c_DEF_TIMEOUT_CYC
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              GO,
    input  logic [NUM_CH-1:0] CH_EN,
    output logic [NUM_CH-1:0] START,
    output logic [NUM_CH-1:0] START2,
    input  logic [NUM_CH-1:0] DONE,
    output logic              BUSY,
    output logic              PASS,
    output logic              FAIL,
    output logic [ITER_W-1:0] ITER_CNT,
    output logic [NUM_CH-1:0] FAIL_MASK
);

    localparam int c_GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [ITER_W-1:0]  c_NUM_ITER = ITER_W'(NUM_ITER);

    state_t              r_state;
    logic [NUM_CH-1:0]   r_mask;
    logic [NUM_CH-1:0]   r_done_seen;
    logic [c_GAP_W-1:0]  r_gap_cnt;
    logic [NUM_CH-1:0]   r_start;
    logic [NUM_CH-1:0]   r_start2;
    logic                r_busy;
    logic                r_pass;
    logic                r_fail;
    logic [ITER_W-1:0]   r_iter_cnt;
    logic [NUM_CH-1:0]   r_fail_mask;

    logic [NUM_CH-1:0]   w_done_now;
    logic [NUM_CH-1:0]   w_seen;
    logic                w_complete;
    logic [ITER_W-1:0]   w_iter_next;
    logic                w_last_iter;
    logic                w_expired;

    assign w_done_now  = DONE & r_mask;
    assign w_seen      = r_done_seen | w_done_now;
    assign w_complete  = (w_seen == r_mask);
    assign w_iter_next = r_iter_cnt + 1'b1;
    assign w_last_iter = (w_iter_next == c_NUM_ITER);

    noc_seq_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .CLK     (CLK),
        .RST     (RST),
        .clear   (r_state != ST_WAIT),
        .enable  (r_state == ST_WAIT),
        .expired (w_expired)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_mask      <= '0;
            r_done_seen <= '0;
            r_gap_cnt   <= '0;
            r_start     <= '0;
            r_start2    <= '0;
            r_busy      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_iter_cnt  <= '0;
            r_fail_mask <= '0;
        end else begin
            r_start  <= '0;
            r_start2 <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (GO) begin
                        r_mask      <= CH_EN;
                        r_busy      <= 1'b1;
                        r_pass      <= 1'b0;
                        r_fail      <= 1'b0;
                        r_iter_cnt  <= '0;
                        r_fail_mask <= '0;
                        if (CH_EN != '0) begin
                            r_state     <= ST_PH1;
                            r_start     <= CH_EN;
                            r_done_seen <= '0;
                        end else begin
                            // Nothing to exercise: trivially passing run
                            r_state <= ST_FINISH;
                            r_pass  <= 1'b1;
                        end
                    end
                end
                ST_PH1: begin
                    r_state  <= ST_PH2;
                    r_start2 <= r_mask;
                end
                ST_PH2: begin
                    r_state     <= ST_WAIT;
                    r_done_seen <= w_seen;
                end
                ST_WAIT: begin
                    r_done_seen <= w_seen;
                    // Completion is tested first so it beats a same-cycle timeout
                    if (w_complete) begin
                        r_iter_cnt <= w_iter_next;
                        if (w_last_iter) begin
                            r_state <= ST_FINISH;
                            r_pass  <= 1'b1;
                        end else if (GAP_CYC == 0) begin
                            r_state     <= ST_PH1;
                            r_start     <= r_mask;
                            r_done_seen <= '0;
                        end else begin
                            r_state   <= ST_GAP;
                            r_gap_cnt <= '0;
                        end
                    end else if (w_expired) begin
                        r_state     <= ST_FINISH;
                        r_fail      <= 1'b1;
                        r_fail_mask <= r_mask & ~w_seen;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == c_GAP_LAST) begin
                        r_state     <= ST_PH1;
                        r_start     <= r_mask;
                        r_done_seen <= '0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign START     = r_start;
    assign START2    = r_start2;
    assign BUSY      = r_busy;
    assign PASS      = r_pass;
    assign FAIL      = r_fail;
    assign ITER_CNT  = r_iter_cnt;
    assign FAIL_MASK = r_fail_mask;

endmodule
`default_nettype wire

// File: tb/tb_noc_inject_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_inject_sequencer
// Brief    : Self-checking bench; START events are scoreboarded against
//            expected (cycle, mask) entries queued when each GO is driven.
// Revision : 1.0 - initial release
// ============================================================================
module tb_noc_inject_sequencer;

    typedef struct {
        int         cyc;
        logic [3:0] mask;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    logic        go0 = 1'b0, go1 = 1'b0;
    logic [3:0]  en0 = '0, en1 = '0;
    logic [3:0]  start0, start2_0, start1, start2_1;
    logic [3:0]  done0, done1;
    logic        busy0, pass0, fail0, busy1, pass1, fail1;
    logic [15:0] iter0, iter1;
    logic [3:0]  fmask0, fmask1;

    logic [3:0]  resp0 = '0, man0 = '0;
    logic [3:0]  d1 = '0, d2 = '0, d3 = '0, d4 = '0;
    logic        ph1_en1 = 1'b0, ph2_en1 = 1'b0;
    logic [3:0]  prev0 = '0, prev1 = '0;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    noc_inject_sequencer #(
        .NUM_CH(4), .NUM_ITER(5), .GAP_CYC(2), .TIMEOUT_CYC(16)
    ) dut0 (
        .CLK(clk), .RST(rst), .GO(go0), .CH_EN(en0), .START(start0), .START2(start2_0),
        .DONE(done0), .BUSY(busy0), .PASS(pass0), .FAIL(fail0), .ITER_CNT(iter0),
        .FAIL_MASK(fmask0)
    );

    noc_inject_sequencer #(
        .NUM_CH(4), .NUM_ITER(5), .GAP_CYC(0), .TIMEOUT_CYC(16)
    ) dut1 (
        .CLK(clk), .RST(rst), .GO(go1), .CH_EN(en1), .START(start1), .START2(start2_1),
        .DONE(done1), .BUSY(busy1), .PASS(pass1), .FAIL(fail1), .ITER_CNT(iter1),
        .FAIL_MASK(fmask1)
    );

    // Channel model for dut0: DONE pulses three cycles after START2
    always @(negedge clk) begin
        d4 = d3; d3 = d2; d2 = d1; d1 = start2_0;
    end
    assign done0 = (d4 & resp0) | man0;
    assign done1 = (ph1_en1 ? start1 : 4'b0) | (ph2_en1 ? start2_1 : 4'b0);

    always @(negedge clk) begin
        exp_t e;
        checks++;
        if (start2_0 !== prev0) begin
            errors++;
            $display("FAIL start2_follow0 cyc=%0d got=%b want=%b", cyc, start2_0, prev0);
        end
        if (start0 !== 4'b0) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL start0_unexpected cyc=%0d got=%b want=none", cyc, start0);
            end else begin
                e = q0.pop_front();
                if (e.cyc != cyc || e.mask !== start0) begin
                    errors++;
                    $display("FAIL start0_event got cyc=%0d mask=%b want cyc=%0d mask=%b",
                             cyc, start0, e.cyc, e.mask);
                end
            end
        end
        prev0 = start0;
    end

    always @(negedge clk) begin
        exp_t e;
        checks++;
        if (start2_1 !== prev1) begin
            errors++;
            $display("FAIL start2_follow1 cyc=%0d got=%b want=%b", cyc, start2_1, prev1);
        end
        if (start1 !== 4'b0) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL start1_unexpected cyc=%0d got=%b want=none", cyc, start1);
            end else begin
                e = q1.pop_front();
                if (e.cyc != cyc || e.mask !== start1) begin
                    errors++;
                    $display("FAIL start1_event got cyc=%0d mask=%b want cyc=%0d mask=%b",
                             cyc, start1, e.cyc, e.mask);
                end
            end
        end
        prev1 = start1;
    end

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({start0, start2_0, busy0, pass0, fail0, iter0, fmask0} !== 31'b0) begin
            errors++;
            $display("FAIL reset_dut0 got=%h want=0", {start0, start2_0, busy0, pass0, fail0, iter0, fmask0});
        end
        checks++;
        if ({start1, start2_1, busy1, pass1, fail1, iter1, fmask1} !== 31'b0) begin
            errors++;
            $display("FAIL reset_dut1 got=%h want=0", {start1, start2_1, busy1, pass1, fail1, iter1, fmask1});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_run;
        exp_t e;
        int   c = cyc;
        int   n = 0;
        resp0 = 4'hF; en0 = 4'hF; go0 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            e.cyc = c + 1 + 7 * k; e.mask = 4'hF; q0.push_back(e);
        end
        @(negedge clk);
        go0 = 1'b0; en0 = 4'h0;
        checks++;
        if (busy0 !== 1'b1) begin
            errors++; $display("FAIL full_busy got=%b want=1", busy0);
        end
        repeat (4) @(negedge clk);
        go0 = 1'b1; en0 = 4'b0011;
        @(negedge clk);
        go0 = 1'b0; en0 = 4'h0;
        while (busy0 === 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (busy0 !== 1'b0) begin errors++; $display("FAIL full_end busy=%b want=0", busy0); end
        checks++;
        if (pass0 !== 1'b1 || fail0 !== 1'b0) begin
            errors++; $display("FAIL full_status pass=%b fail=%b want pass=1 fail=0", pass0, fail0);
        end
        checks++;
        if (iter0 !== 16'd5) begin errors++; $display("FAIL full_iter got=%0d want=5", iter0); end
        @(negedge clk);
        checks++;
        if (pass0 !== 1'b1 || q0.size() != 0) begin
            errors++; $display("FAIL full_sticky pass=%b pending=%0d want pass=1 pending=0", pass0, q0.size());
        end
        q0.delete();
    endtask

    task automatic test_timeout;
        exp_t e;
        int   c = cyc;
        int   n = 0;
        resp0 = 4'b0001; en0 = 4'b0101; go0 = 1'b1;
        e.cyc = c + 1; e.mask = 4'b0101; q0.push_back(e);
        @(negedge clk);
        go0 = 1'b0; en0 = 4'h0;
        checks++;
        if (pass0 !== 1'b0) begin errors++; $display("FAIL timeout_pass_clear got=%b want=0", pass0); end
        while (busy0 === 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (cyc != c + 20) begin errors++; $display("FAIL timeout_latency got=%0d want=%0d", cyc - c, 20); end
        checks++;
        if (fail0 !== 1'b1 || pass0 !== 1'b0) begin
            errors++; $display("FAIL timeout_status fail=%b pass=%b want fail=1 pass=0", fail0, pass0);
        end
        checks++;
        if (fmask0 !== 4'b0100) begin errors++; $display("FAIL timeout_mask got=%b want=0100", fmask0); end
        checks++;
        if (iter0 !== 16'd0) begin errors++; $display("FAIL timeout_iter got=%0d want=0", iter0); end
        resp0 = 4'b0;
        q0.delete();
    endtask

    task automatic test_empty_mask;
        int c = cyc;
        en0 = 4'b0; go0 = 1'b1;
        @(negedge clk);
        go0 = 1'b0;
        checks++;
        if (pass0 !== 1'b1 || busy0 !== 1'b1) begin
            errors++; $display("FAIL empty_first pass=%b busy=%b want pass=1 busy=1", pass0, busy0);
        end
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || pass0 !== 1'b1 || fail0 !== 1'b0) begin
            errors++; $display("FAIL empty_done busy=%b pass=%b fail=%b want 0 1 0", busy0, pass0, fail0);
        end
        checks++;
        if (iter0 !== 16'd0 || fmask0 !== 4'b0) begin
            errors++; $display("FAIL empty_clear iter=%0d fmask=%b want 0 0000", iter0, fmask0);
        end
        checks++;
        if (cyc != c + 2) begin errors++; $display("FAIL empty_cycle got=%0d want=2", cyc - c); end
    endtask

    task automatic test_timeout_edge;
        exp_t e;
        int   c = cyc;
        int   n = 0;
        resp0 = 4'b0; man0 = 4'b0; en0 = 4'b0001; go0 = 1'b1;
        e.cyc = c + 1; e.mask = 4'b0001; q0.push_back(e);
        for (int k = 0; k < 4; k++) begin
            e.cyc = c + 21 + 7 * k; e.mask = 4'b0001; q0.push_back(e);
        end
        @(negedge clk);
        go0 = 1'b0; en0 = 4'h0;
        while (cyc < c + 18 && n < 40) begin @(negedge clk); n++; end
        man0 = 4'b0001;
        @(negedge clk);
        man0 = 4'b0;
        checks++;
        if (iter0 !== 16'd1 || fail0 !== 1'b0 || busy0 !== 1'b1) begin
            errors++; $display("FAIL edge_count iter=%0d fail=%b busy=%b want 1 0 1", iter0, fail0, busy0);
        end
        resp0 = 4'b0001;
        n = 0;
        while (busy0 === 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (pass0 !== 1'b1 || fail0 !== 1'b0 || iter0 !== 16'd5) begin
            errors++; $display("FAIL edge_final pass=%b fail=%b iter=%0d want 1 0 5", pass0, fail0, iter0);
        end
        checks++;
        if (q0.size() != 0) begin errors++; $display("FAIL edge_pending got=%0d want=0", q0.size()); end
        q0.delete();
        resp0 = 4'b0;
    endtask

    task automatic test_reset_midrun;
        exp_t e;
        int   c = cyc;
        int   n = 0;
        resp0 = 4'hF; en0 = 4'hF; go0 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            e.cyc = c + 1 + 7 * k; e.mask = 4'hF; q0.push_back(e);
        end
        @(negedge clk);
        go0 = 1'b0;
        while (cyc < c + 17 && n < 40) begin @(negedge clk); n++; end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({start0, start2_0, busy0, pass0, fail0, iter0, fmask0} !== 31'b0) begin
            errors++;
            $display("FAIL midreset_outputs got=%h want=0", {start0, start2_0, busy0, pass0, fail0, iter0, fmask0});
        end
        repeat (10) @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || q0.size() != 0) begin
            errors++; $display("FAIL midreset_idle busy=%b pending=%0d want 0 0", busy0, q0.size());
        end
        q0.delete();
        c = cyc;
        go0 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            e.cyc = c + 1 + 7 * k; e.mask = 4'hF; q0.push_back(e);
        end
        @(negedge clk);
        go0 = 1'b0; en0 = 4'h0;
        n = 0;
        while (busy0 === 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (pass0 !== 1'b1 || iter0 !== 16'd5 || q0.size() != 0) begin
            errors++; $display("FAIL midreset_rerun pass=%b iter=%0d pending=%0d want 1 5 0", pass0, iter0, q0.size());
        end
        q0.delete();
        resp0 = 4'b0;
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   c = cyc;
        int   n = 0;
        ph1_en1 = 1'b1; ph2_en1 = 1'b1; en1 = 4'hF; go1 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            e.cyc = c + 1 + 3 * k; e.mask = 4'hF; q1.push_back(e);
        end
        @(negedge clk);
        go1 = 1'b0; en1 = 4'h0;
        while (busy1 === 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (pass1 !== 1'b1 || fail1 !== 1'b0 || iter1 !== 16'd5) begin
            errors++; $display("FAIL b2b_final pass=%b fail=%b iter=%0d want 1 0 5", pass1, fail1, iter1);
        end
        checks++;
        if (cyc != c + 17 || q1.size() != 0) begin
            errors++; $display("FAIL b2b_timing end=%0d pending=%0d want end=17 pending=0", cyc - c, q1.size());
        end
        q1.delete();
    endtask

    task automatic test_ph1_done_ignored;
        exp_t e;
        int   c = cyc;
        int   n = 0;
        ph1_en1 = 1'b1; ph2_en1 = 1'b0; en1 = 4'hF; go1 = 1'b1;
        e.cyc = c + 1; e.mask = 4'hF; q1.push_back(e);
        @(negedge clk);
        go1 = 1'b0; en1 = 4'h0;
        while (busy1 === 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (fail1 !== 1'b1 || pass1 !== 1'b0 || iter1 !== 16'd0) begin
            errors++; $display("FAIL ph1_ignored fail=%b pass=%b iter=%0d want 1 0 0", fail1, pass1, iter1);
        end
        checks++;
        if (fmask1 !== 4'hF) begin errors++; $display("FAIL ph1_fmask got=%b want=1111", fmask1); end
        q1.delete();
        ph1_en1 = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_full_run();
        test_timeout();
        test_empty_mask();
        test_timeout_edge();
        test_reset_midrun();
        test_back_to_back();
        test_ph1_done_ignored();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout cyc=%0d want completion", cyc);
        $fatal(1, "bench did not complete");
    end

endmodule
`default_nettype wire
